// File: rtl/packet_injector_pkg.sv
// Shared packet layout and injector FSM state type, used by the injector,
// the router and the local sink.
package packet_injector_pkg;

  localparam int PKT_W      = 256;
  localparam int VALID_POS  = 255;
  // Priority and exit fields belong to the router; injected packets leave them zero.
  localparam int PRIO_POS   = 156;
  localparam int PRIO_W     = 4;
  localparam int EXIT_POS   = 152;
  localparam int EXIT_W     = 4;
  localparam int WEIGHT_POS = 144;
  localparam int WEIGHT_W   = 8;
  localparam int INDEX_POS  = 128;
  localparam int INDEX_W    = 16;
  localparam int TYPE_POS   = 96;
  localparam int TYPE_W     = 32;
  localparam int Z_POS      = 64;
  localparam int Y_POS      = 32;
  localparam int X_POS      = 0;
  localparam int COORD_W    = 32;
  localparam int SENT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } inj_state_e;

endpackage

// File: rtl/packet_injector_if.sv
// Injection channel between a packet source (master) and the router's
// local injection port (slave).
interface packet_injector_if #(
  parameter int DataWidth = 256
) ();
  logic [DataWidth-1:0] inject_local;
  logic                 inject_send_local;
  logic                 InjectSlotAvail;

  modport master (
    output inject_local,
    output inject_send_local,
    input  InjectSlotAvail
  );

  modport slave (
    input  inject_local,
    input  inject_send_local,
    output InjectSlotAvail
  );
endinterface

// File: rtl/packet_injector_gap_timer.sv
// Loadable down-counter; expire_o is high during the last cycle of the
// loaded interval.
module inject_gap_timer #(
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  output logic                expire_o
);

  logic [CntWidth-1:0] count_q;
  logic [CntWidth-1:0] count_d;
  logic                expire_q;

  // Next count: reload, count down to zero, then hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CntWidth'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter and registered expire flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= (count_d == CntWidth'(1));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/packet_injector.sv
// Injects packet_count indexed packets into the local router port per run.
// Optional INJECT_THROTTLE_EN inserts GapCycles idle cycles after each send.
module packet_injector
  import packet_injector_pkg::*;
#(
  parameter logic [3:0]  X            = 4'd0,
  parameter logic [3:0]  Y            = 4'd0,
  parameter logic [3:0]  Z            = 4'd0,
  parameter int          packet_count = 256,
  parameter int          DataWidth    = PKT_W,
  parameter int          IndexPos     = INDEX_POS,
  parameter int          IndexWidth   = INDEX_W,
  parameter int          WeightPos    = WEIGHT_POS,
  parameter int          WeightWidth  = WEIGHT_W,
  parameter logic [7:0]  WeightInit   = 8'd0,
  parameter logic [31:0] PcktType     = 32'd1,
  parameter int          GapCycles    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  packet_injector_if.master     inj,
  output logic                  busy,
  output logic                  done,
  output logic [SENT_W-1:0]     sent_count
);

  inj_state_e           state_q, state_d;
  logic [SENT_W-1:0]    sent_q, sent_d;
  logic                 send_q, send_d;
  logic [DataWidth-1:0] pkt_q, pkt_d;
  logic                 busy_q, done_q;
  logic                 full_s, last_s;
  logic                 gap_load_s, gap_expire_s;

`ifdef INJECT_THROTTLE_EN
  localparam bit ThrottleOn = (GapCycles > 0);

  inject_gap_timer #(
    .CntWidth (SENT_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load_s),
    .load_val_i (SENT_W'(GapCycles)),
    .expire_o   (gap_expire_s)
  );
`else
  localparam bit ThrottleOn = 1'b0;
  logic unused_gap_s;

  assign gap_expire_s = 1'b0;
  assign unused_gap_s = gap_load_s;
`endif

  function automatic logic [DataWidth-1:0] build_packet(input logic [SENT_W-1:0] idx);
    logic [DataWidth-1:0] p;
    p = '0;
    p[DataWidth-1]                = 1'b1;
    p[WeightPos +: WeightWidth]   = WeightWidth'(WeightInit);
    p[IndexPos +: IndexWidth]     = IndexWidth'(idx);
    p[TYPE_POS +: TYPE_W]         = PcktType;
    p[Z_POS +: COORD_W]           = COORD_W'(Z);
    p[Y_POS +: COORD_W]           = COORD_W'(Y);
    p[X_POS +: COORD_W]           = COORD_W'(X);
    return p;
  endfunction

  assign full_s = (32'(sent_q) >= packet_count);
  assign last_s = ((32'(sent_q) + 32'd1) >= packet_count);

  // Next-state, packet and counter logic; the run finishes one cycle after its last send.
  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    send_d     = 1'b0;
    pkt_d      = '0;
    gap_load_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sent_d  = '0;
          state_d = (packet_count == 0) ? DONE : RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (full_s) begin
          state_d = DONE;
        end else if (inj.InjectSlotAvail) begin
          send_d = 1'b1;
          pkt_d  = build_packet(sent_q);
          sent_d = sent_q + 16'd1;
          if (ThrottleOn && !last_s) begin
            state_d    = GAP;
            gap_load_s = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      GAP: begin
        if (gap_expire_s) begin
          state_d = RUN;
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sent_q  <= '0;
      send_q  <= 1'b0;
      pkt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      send_q  <= send_d;
      pkt_q   <= pkt_d;
      busy_q  <= (state_d == RUN) || (state_d == GAP);
      done_q  <= (state_d == DONE);
    end
  end

  assign inj.inject_local      = pkt_q;
  assign inj.inject_send_local = send_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign sent_count            = sent_q;

endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: randomized traffic against a
// timestamp-based reference model plus directed field/zero-count checks.
module tb_packet_injector;

  localparam int GAP  = 4;
  localparam int M_PC = 8;
`ifdef INJECT_THROTTLE_EN
  localparam int SPACING = (GAP > 0) ? GAP + 1 : 1;
`else
  localparam int SPACING = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main randomized DUT
  logic        m_rst, m_start, m_busy, m_done;
  logic [15:0] m_cnt;
  packet_injector_if #(.DataWidth(256)) m_if ();
  packet_injector #(
    .X(4'd5), .Y(4'd6), .Z(4'd7), .packet_count(M_PC), .WeightInit(8'h3C),
    .PcktType(32'hCAFE_0001), .GapCycles(GAP)
  ) dut_m (
    .clk(clk), .rst(m_rst), .start(m_start), .inj(m_if.master),
    .busy(m_busy), .done(m_done), .sent_count(m_cnt)
  );

  // Directed field / sequence DUT
  logic        a_rst, a_start, a_busy, a_done;
  logic [15:0] a_cnt;
  packet_injector_if #(.DataWidth(256)) a_if ();
  packet_injector #(
    .X(4'd1), .Y(4'd2), .Z(4'd3), .packet_count(4), .WeightInit(8'h05),
    .PcktType(32'd1), .GapCycles(GAP)
  ) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .inj(a_if.master),
    .busy(a_busy), .done(a_done), .sent_count(a_cnt)
  );

  // Zero-packet DUT
  logic        z_rst, z_start, z_busy, z_done;
  logic [15:0] z_cnt;
  packet_injector_if #(.DataWidth(256)) z_if ();
  packet_injector #(
    .packet_count(0), .GapCycles(GAP)
  ) dut_z (
    .clk(clk), .rst(z_rst), .start(z_start), .inj(z_if.master),
    .busy(z_busy), .done(z_done), .sent_count(z_cnt)
  );

  // Reference model state for dut_m
  bit mdl_active, mdl_done, mdl_exp_send;
  int mdl_sent, mdl_last, mdl_edge, mdl_exp_idx;
  logic [255:0] exp_data;

  function automatic logic [255:0] exp_pkt(input logic [7:0] w, input logic [15:0] idx,
                                            input logic [31:0] typ, input logic [3:0] x,
                                            input logic [3:0] y, input logic [3:0] z);
    return {1'b1, 103'd0, w, idx, typ, 28'd0, z, 28'd0, y, 28'd0, x};
  endfunction

  // Model: a run accepts a packet on any edge with the slot free, at least
  // SPACING edges after its previous accept; it ends one edge after the last.
  task automatic model_step(input bit st, input bit av, input bit rs);
    mdl_edge++;
    mdl_exp_send = 1'b0;
    if (rs) begin
      mdl_active = 1'b0; mdl_done = 1'b0; mdl_sent = 0;
    end else if (mdl_active) begin
      if (mdl_sent == M_PC) begin
        mdl_active = 1'b0; mdl_done = 1'b1;
      end else if (av && (mdl_edge - mdl_last) >= SPACING) begin
        mdl_exp_send = 1'b1; mdl_exp_idx = mdl_sent; mdl_sent++; mdl_last = mdl_edge;
      end
    end else if (st) begin
      mdl_sent = 0; mdl_done = (M_PC == 0); mdl_active = (M_PC != 0); mdl_last = -1000;
    end
    exp_data = mdl_exp_send ? exp_pkt(8'h3C, 16'(mdl_exp_idx), 32'hCAFE_0001, 4'd5, 4'd6, 4'd7) : '0;
  endtask

  task automatic m_drive_edge(input bit st, input bit av, input bit rs);
    m_start = st; m_if.InjectSlotAvail = av; m_rst = rs;
    @(posedge clk);
    model_step(st, av, rs);
    #1;
    m_start = 1'b0; m_rst = 1'b0;
  endtask

  task automatic test_reset();
    m_rst = 1'b1; a_rst = 1'b1; z_rst = 1'b1;
    m_start = 1'b0; a_start = 1'b0; z_start = 1'b0;
    m_if.InjectSlotAvail = 1'b1; a_if.InjectSlotAvail = 1'b1; z_if.InjectSlotAvail = 1'b1;
    repeat (2) @(posedge clk);
    model_step(1'b0, 1'b1, 1'b1);
    #1;
    m_rst = 1'b0; a_rst = 1'b0; z_rst = 1'b0;
    checks++; if ({m_busy, m_done, m_if.inject_send_local} !== 3'b000) begin failures++; $display("FAIL reset_m_flags got %b expected 000", {m_busy, m_done, m_if.inject_send_local}); end
    checks++; if (m_cnt !== 16'd0) begin failures++; $display("FAIL reset_m_cnt got %0d expected 0", m_cnt); end
    checks++; if (m_if.inject_local !== 256'd0) begin failures++; $display("FAIL reset_m_data got %h expected 0", m_if.inject_local); end
    checks++; if ({a_busy, a_done, a_if.inject_send_local, z_busy, z_done, z_if.inject_send_local} !== 6'd0) begin failures++; $display("FAIL reset_az_flags got %b expected 000000", {a_busy, a_done, a_if.inject_send_local, z_busy, z_done, z_if.inject_send_local}); end
    checks++; if ({a_cnt, z_cnt} !== 32'd0) begin failures++; $display("FAIL reset_az_cnt got %h expected 0", {a_cnt, z_cnt}); end
  endtask

  task automatic test_random_traffic();
    for (int c = 0; c < 240; c++) begin
      bit st, av;
      st = (c == 0) || ($urandom_range(0, 15) == 0);
      av = ($urandom_range(0, 3) != 0);
      m_drive_edge(st, av, 1'b0);
      checks++; if (m_if.inject_send_local !== mdl_exp_send) begin failures++; $display("FAIL rnd_send cyc=%0d got %b expected %b", c, m_if.inject_send_local, mdl_exp_send); end
      checks++; if (m_if.inject_local !== exp_data) begin failures++; $display("FAIL rnd_data cyc=%0d got %h expected %h", c, m_if.inject_local, exp_data); end
      checks++; if ({m_busy, m_done} !== {mdl_active, mdl_done}) begin failures++; $display("FAIL rnd_busy_done cyc=%0d got %b expected %b", c, {m_busy, m_done}, {mdl_active, mdl_done}); end
      checks++; if (m_cnt !== 16'(mdl_sent)) begin failures++; $display("FAIL rnd_cnt cyc=%0d got %0d expected %0d", c, m_cnt, mdl_sent); end
    end
  endtask

  task automatic test_reset_midrun();
    int guard;
    m_drive_edge(1'b0, 1'b0, 1'b1);
    m_drive_edge(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (mdl_sent < 2 && guard < 50) begin
      m_drive_edge(1'b0, 1'b1, 1'b0);
      guard++;
    end
    checks++; if (m_cnt !== 16'd2) begin failures++; $display("FAIL midrun_pre_cnt got %0d expected 2", m_cnt); end
    m_drive_edge(1'b0, 1'b1, 1'b1);
    checks++; if (m_if.inject_send_local !== 1'b0 || m_if.inject_local !== 256'd0) begin failures++; $display("FAIL midrun_rst_out got %b/%h expected 0/0", m_if.inject_send_local, m_if.inject_local); end
    checks++; if ({m_busy, m_done, m_cnt} !== 18'd0) begin failures++; $display("FAIL midrun_rst_state got %h expected 0", {m_busy, m_done, m_cnt}); end
    m_drive_edge(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!mdl_done && guard < 200) begin
      m_drive_edge(1'b0, ($urandom_range(0, 2) != 0), 1'b0);
      guard++;
      checks++; if (m_if.inject_send_local !== mdl_exp_send || m_if.inject_local !== exp_data) begin failures++; $display("FAIL restart_send got %b/%h expected %b/%h", m_if.inject_send_local, m_if.inject_local, mdl_exp_send, exp_data); end
      checks++; if (m_cnt !== 16'(mdl_sent) || m_done !== mdl_done) begin failures++; $display("FAIL restart_cnt got %0d/%b expected %0d/%b", m_cnt, m_done, mdl_sent, mdl_done); end
    end
    checks++; if (guard >= 200) begin failures++; $display("FAIL restart_timeout got guard=%0d expected <200", guard); end
  endtask

  task automatic test_fields_and_sequence();
    int nsent, last_c, done_c;
    logic [255:0] pkt0;
    pkt0 = {1'b1, 103'd0, 8'h05, 16'h0000, 32'd1, 32'd3, 32'd2, 32'd1};
    nsent = 0; last_c = -1; done_c = -1;
    a_if.InjectSlotAvail = 1'b1; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 1; c <= 4 * SPACING + 6; c++) begin
      if (c == 2) a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      if (a_if.inject_send_local === 1'b1) begin
        checks++; if (a_if.inject_local[143:128] !== 16'(nsent)) begin failures++; $display("FAIL seq_idx got %0d expected %0d", a_if.inject_local[143:128], nsent); end
        if (nsent == 0) begin
          checks++; if (a_if.inject_local !== pkt0) begin failures++; $display("FAIL pkt0_fields got %h expected %h", a_if.inject_local, pkt0); end
          checks++; if (c !== 1) begin failures++; $display("FAIL first_latency got %0d expected 1", c); end
        end else begin
          checks++; if (c - last_c !== SPACING) begin failures++; $display("FAIL spacing got %0d expected %0d", c - last_c, SPACING); end
        end
        nsent++; last_c = c;
      end else begin
        checks++; if (a_if.inject_local !== 256'd0) begin failures++; $display("FAIL idle_data got %h expected 0", a_if.inject_local); end
      end
      if (a_done === 1'b1 && done_c < 0) done_c = c;
    end
    checks++; if (nsent !== 4) begin failures++; $display("FAIL a_num_sent got %0d expected 4", nsent); end
    checks++; if (done_c !== last_c + 1) begin failures++; $display("FAIL a_done_cycle got %0d expected %0d", done_c, last_c + 1); end
    checks++; if (a_cnt !== 16'd4 || a_busy !== 1'b0) begin failures++; $display("FAIL a_final got cnt=%0d busy=%b expected 4/0", a_cnt, a_busy); end
  endtask

  task automatic test_zero_count();
    z_if.InjectSlotAvail = 1'b1; z_start = 1'b1;
    @(posedge clk); #1;
    z_start = 1'b0;
    checks++; if ({z_done, z_busy, z_if.inject_send_local} !== 3'b100) begin failures++; $display("FAIL zero_start got %b expected 100", {z_done, z_busy, z_if.inject_send_local}); end
    for (int c = 0; c < 4; c++) begin
      z_start = (c == 1);
      @(posedge clk); #1;
      checks++; if (z_if.inject_send_local !== 1'b0 || z_cnt !== 16'd0 || z_done !== 1'b1) begin failures++; $display("FAIL zero_hold cyc=%0d got send=%b cnt=%0d done=%b expected 0/0/1", c, z_if.inject_send_local, z_cnt, z_done); end
    end
    z_start = 1'b0;
  endtask

  initial begin
    mdl_active = 1'b0; mdl_done = 1'b0; mdl_exp_send = 1'b0;
    mdl_sent = 0; mdl_last = -1000; mdl_edge = 0; mdl_exp_idx = 0;
    test_reset();
    test_random_traffic();
    test_reset_midrun();
    test_fields_and_sequence();
    test_zero_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
